irq_prio_encoder: RTL and testbench

IRQ_PRIO_ENCODER -- requirements
Module: irq_prio_encoder

---
 rtl/irq_prio_encoder_if.sv | 21 ++
 rtl/irq_prio_encoder.sv | 123 ++++++++++++
 tb/tb_irq_prio_encoder.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_prio_encoder_if.sv
// Request/grant bundle for irq_prio_encoder: request lines, mask and ack in;
// interrupt, vector, pending image and timeout pulse out.
interface irq_prio_encoder_if;
  logic [7:0] req_n;
  logic [7:0] mask;
  logic       ack;
  logic       irq_n;
  logic [2:0] vec;
  logic [7:0] pending;
  logic       timeout_p;

  modport master (
    output req_n, mask, ack,
    input  irq_n, vec, pending, timeout_p
  );

  modport slave (
    input  req_n, mask, ack,
    output irq_n, vec, pending, timeout_p
  );
endinterface

// File: rtl/irq_prio_encoder.sv
// Eight-line priority interrupt encoder with IDLE/ACTIVE/GAP grant FSM and ack timeout.
// Define IRQ_EDGE_TRIG_EN for falling-edge latched requests; default is level mode.
module irq_prio_encoder #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic              clk,
  input logic              reset,
  irq_prio_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    GAP
  } state_e;

  localparam bit         TimeoutEn = (TIMEOUT != 0);
  localparam logic [7:0] CntLast   = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] req_s_q;
  logic [7:0] pending_q, pending_d;
  logic [7:0] arb_src, cand;
  logic [2:0] vec_q, vec_d, win;
  logic       irq_n_q, irq_n_d;
  logic       tout_q, tout_d;
  logic [7:0] cnt_q, cnt_d;

`ifdef IRQ_EDGE_TRIG_EN
  logic [7:0] req_p_q;
  logic [7:0] set_m, clr_m;

  always_ff @(posedge clk) begin
    if (reset) req_p_q <= '1;
    else       req_p_q <= req_s_q;
  end

  // A new edge and an ack clearing the same bit in one cycle: the edge wins.
  always_comb begin
    set_m     = req_p_q & ~req_s_q;
    clr_m     = (state_q == ACTIVE && bus.ack) ? (8'd1 << vec_q) : '0;
    pending_d = (pending_q & ~clr_m) | set_m;
  end

  assign arb_src = pending_q;
`else
  assign pending_d = ~req_s_q;
  // Arbitrating on the value being latched saves one edge of latency.
  assign arb_src   = pending_d;
`endif

  assign cand = arb_src & bus.mask;

  always_comb begin
    win = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (cand[i]) win = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    irq_n_d = 1'b1;
    tout_d  = 1'b0;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (|cand) begin
          state_d = ACTIVE;
          vec_d   = win;
          irq_n_d = 1'b0;
        end
      end
      ACTIVE: begin
        irq_n_d = 1'b0;
        if (TimeoutEn) cnt_d = cnt_q + 8'd1;
        if (bus.ack) begin
          state_d = GAP;
          irq_n_d = 1'b1;
          cnt_d   = '0;
        end else if (TimeoutEn && cnt_q == CntLast) begin
          state_d = GAP;
          irq_n_d = 1'b1;
          tout_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      req_s_q   <= '1;
      pending_q <= '0;
      vec_q     <= '0;
      irq_n_q   <= 1'b1;
      tout_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_s_q   <= bus.req_n;
      pending_q <= pending_d;
      vec_q     <= vec_d;
      irq_n_q   <= irq_n_d;
      tout_q    <= tout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.irq_n     = irq_n_q;
  assign bus.vec       = vec_q;
  assign bus.pending   = pending_q;
  assign bus.timeout_p = tout_q;

endmodule

// File: tb/tb_irq_prio_encoder.sv
// Directed bench for irq_prio_encoder (TIMEOUT=4); expectations follow IRQ_EDGE_TRIG_EN.
module tb_irq_prio_encoder;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  irq_prio_encoder_if bus_if ();

  irq_prio_encoder #(.TIMEOUT(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req_n;
    logic [7:0] mask;
    logic       ack;
    logic       irq_n;
    logic [2:0] vec;
    logic [7:0] pend;
  } row_t;

  row_t tbl[$];

`ifdef IRQ_EDGE_TRIG_EN
  localparam int         LAT          = 3;
  localparam logic [7:0] PEND_TO_ACK  = 8'h00;
  localparam logic [7:0] PEND_PRE_ACK = 8'h80;
  localparam logic [7:0] ML_PEND      = 8'h01;
  localparam logic       ML_IRQ_N     = 1'b0;
`else
  localparam int         LAT          = 2;
  localparam logic [7:0] PEND_TO_ACK  = 8'h20;
  localparam logic [7:0] PEND_PRE_ACK = 8'h82;
  localparam logic [7:0] ML_PEND      = 8'h00;
  localparam logic       ML_IRQ_N     = 1'b1;
`endif

  function automatic row_t mk(logic [7:0] r, logic [7:0] m, logic a,
                              logic i, logic [2:0] v, logic [7:0] p);
    row_t x;
    x.req_n = r; x.mask = m; x.ack = a;
    x.irq_n = i; x.vec = v; x.pend = p;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;

`ifdef IRQ_EDGE_TRIG_EN
    tbl.push_back(mk(8'hF7, 8'hFF, 0, 1, 0, 8'h00));
    tbl.push_back(mk(8'hF7, 8'hFF, 0, 1, 0, 8'h08));
    tbl.push_back(mk(8'hF7, 8'hFF, 1, 0, 3, 8'h08));
    tbl.push_back(mk(8'hF7, 8'hFF, 1, 1, 3, 8'h00));
    tbl.push_back(mk(8'hFF, 8'hFF, 0, 1, 3, 8'h00));
    tbl.push_back(mk(8'hFF, 8'hFF, 0, 1, 3, 8'h00));
    tbl.push_back(mk(8'hBB, 8'hFF, 0, 1, 3, 8'h00));
    tbl.push_back(mk(8'hBB, 8'hFF, 0, 1, 3, 8'h44));
    tbl.push_back(mk(8'hBB, 8'hFF, 0, 0, 6, 8'h44));
    tbl.push_back(mk(8'hFF, 8'hFF, 1, 1, 6, 8'h04));
    tbl.push_back(mk(8'hFF, 8'hFF, 0, 1, 6, 8'h04));
    tbl.push_back(mk(8'hFF, 8'hFF, 0, 0, 2, 8'h04));
    tbl.push_back(mk(8'hFF, 8'hFF, 1, 1, 2, 8'h00));
    tbl.push_back(mk(8'hFF, 8'hFF, 0, 1, 2, 8'h00));
    tbl.push_back(mk(8'h7F, 8'h7F, 0, 1, 2, 8'h00));
    tbl.push_back(mk(8'h7F, 8'h7F, 0, 1, 2, 8'h80));
    tbl.push_back(mk(8'h7F, 8'h7F, 0, 1, 2, 8'h80));
    tbl.push_back(mk(8'h7F, 8'hFF, 0, 0, 7, 8'h80));
    tbl.push_back(mk(8'h7F, 8'hFF, 1, 1, 7, 8'h00));
    tbl.push_back(mk(8'hFF, 8'hFF, 0, 1, 7, 8'h00));
`else
    tbl.push_back(mk(8'hF7, 8'hFF, 0, 1, 0, 8'h00));
    tbl.push_back(mk(8'hF7, 8'hFF, 0, 0, 3, 8'h08));
    tbl.push_back(mk(8'hF7, 8'hFF, 1, 1, 3, 8'h08));
    tbl.push_back(mk(8'hFF, 8'hFF, 0, 1, 3, 8'h08));
    tbl.push_back(mk(8'hFF, 8'hFF, 0, 1, 3, 8'h00));
    tbl.push_back(mk(8'hBB, 8'hFF, 0, 1, 3, 8'h00));
    tbl.push_back(mk(8'hBB, 8'hFF, 0, 0, 6, 8'h44));
    tbl.push_back(mk(8'hBB, 8'hFF, 1, 1, 6, 8'h44));
    tbl.push_back(mk(8'hFB, 8'hFF, 0, 1, 6, 8'h44));
    tbl.push_back(mk(8'hFB, 8'hFF, 0, 0, 2, 8'h04));
    tbl.push_back(mk(8'hFB, 8'hFF, 1, 1, 2, 8'h04));
    tbl.push_back(mk(8'hFF, 8'hFF, 0, 1, 2, 8'h04));
    tbl.push_back(mk(8'hFF, 8'hFF, 0, 1, 2, 8'h00));
    tbl.push_back(mk(8'h7F, 8'h7F, 0, 1, 2, 8'h00));
    tbl.push_back(mk(8'h7F, 8'h7F, 0, 1, 2, 8'h80));
    tbl.push_back(mk(8'h7F, 8'hFF, 0, 0, 7, 8'h80));
    tbl.push_back(mk(8'h7F, 8'hFF, 1, 1, 7, 8'h80));
    tbl.push_back(mk(8'hFF, 8'hFF, 0, 1, 7, 8'h80));
    tbl.push_back(mk(8'hFF, 8'hFF, 0, 1, 7, 8'h00));
`endif

    reset         = 1'b1;
    bus_if.req_n  = 8'hFF;
    bus_if.mask   = 8'hFF;
    bus_if.ack    = 1'b0;
    step(3);
    chk("reset irq_n", 32'(bus_if.irq_n), 32'h1);
    chk("reset vec", 32'(bus_if.vec), 32'h0);
    chk("reset pending", 32'(bus_if.pending), 32'h0);
    chk("reset timeout_p", 32'(bus_if.timeout_p), 32'h0);
    reset = 1'b0;
    step(2);

    // Cycle-by-cycle vectors: single request, two simultaneous, masked request
    for (int i = 0; i < tbl.size(); i++) begin
      bus_if.req_n = tbl[i].req_n;
      bus_if.mask  = tbl[i].mask;
      bus_if.ack   = tbl[i].ack;
      step(1);
      chk($sformatf("row%0d irq_n", i), 32'(bus_if.irq_n), 32'(tbl[i].irq_n));
      chk($sformatf("row%0d vec", i), 32'(bus_if.vec), 32'(tbl[i].vec));
      chk($sformatf("row%0d pending", i), 32'(bus_if.pending), 32'(tbl[i].pend));
      chk($sformatf("row%0d timeout_p", i), 32'(bus_if.timeout_p), 32'h0);
    end
    bus_if.req_n = 8'hFF;
    bus_if.mask  = 8'hFF;
    bus_if.ack   = 1'b0;
    step(2);

    // Request arrives and leaves while masked
    bus_if.mask  = 8'h00;
    bus_if.req_n = 8'hFE;
    step(2);
    chk("mloss irq_n masked", 32'(bus_if.irq_n), 32'h1);
    chk("mloss pending held", 32'(bus_if.pending), 32'h01);
    bus_if.req_n = 8'hFF;
    step(2);
    chk("mloss pending released", 32'(bus_if.pending), 32'(ML_PEND));
    bus_if.mask = 8'hFF;
    step(1);
    chk("mloss irq_n unmasked", 32'(bus_if.irq_n), 32'(ML_IRQ_N));
    bus_if.ack = 1'b1;
    step(1);
    bus_if.ack = 1'b0;
    step(2);
    chk("mloss idle irq_n", 32'(bus_if.irq_n), 32'h1);
    chk("mloss idle pending", 32'(bus_if.pending), 32'h00);

    // Timeout with no ack, regrant, then ack on the expiry cycle
    bus_if.req_n = 8'hDF;
    step(LAT);
    chk("to grant irq_n", 32'(bus_if.irq_n), 32'h0);
    chk("to grant vec", 32'(bus_if.vec), 32'h5);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk($sformatf("to low%0d irq_n", i), 32'(bus_if.irq_n), 32'h0);
      chk($sformatf("to low%0d timeout_p", i), 32'(bus_if.timeout_p), 32'h0);
    end
    step(1);
    chk("to expire irq_n", 32'(bus_if.irq_n), 32'h1);
    chk("to expire timeout_p", 32'(bus_if.timeout_p), 32'h1);
    chk("to expire pending", 32'(bus_if.pending), 32'h20);
    step(1);
    chk("to gap irq_n", 32'(bus_if.irq_n), 32'h1);
    chk("to gap timeout_p", 32'(bus_if.timeout_p), 32'h0);
    step(1);
    chk("to regrant irq_n", 32'(bus_if.irq_n), 32'h0);
    chk("to regrant vec", 32'(bus_if.vec), 32'h5);
    step(3);
    chk("to before race irq_n", 32'(bus_if.irq_n), 32'h0);
    bus_if.ack = 1'b1;
    step(1);
    chk("to race irq_n", 32'(bus_if.irq_n), 32'h1);
    chk("to race timeout_p", 32'(bus_if.timeout_p), 32'h0);
    chk("to race pending", 32'(bus_if.pending), 32'(PEND_TO_ACK));
    bus_if.ack   = 1'b0;
    bus_if.req_n = 8'hFF;
    step(2);
    chk("to end irq_n", 32'(bus_if.irq_n), 32'h1);
    chk("to end pending", 32'(bus_if.pending), 32'h00);

    // Higher priority arrival while ACTIVE does not move vec
    bus_if.req_n = 8'hFD;
    step(LAT);
    chk("pre grant vec", 32'(bus_if.vec), 32'h1);
    chk("pre grant irq_n", 32'(bus_if.irq_n), 32'h0);
    bus_if.req_n = 8'h7D;
    step(2);
    chk("pre hold vec", 32'(bus_if.vec), 32'h1);
    chk("pre hold irq_n", 32'(bus_if.irq_n), 32'h0);
    chk("pre hold pending", 32'(bus_if.pending), 32'h82);
    bus_if.ack   = 1'b1;
    bus_if.req_n = 8'h7F;
    step(1);
    chk("pre ack irq_n", 32'(bus_if.irq_n), 32'h1);
    chk("pre ack vec", 32'(bus_if.vec), 32'h1);
    chk("pre ack pending", 32'(bus_if.pending), 32'(PEND_PRE_ACK));
    bus_if.ack = 1'b0;
    step(1);
    chk("pre gap irq_n", 32'(bus_if.irq_n), 32'h1);
    step(1);
    chk("pre next vec", 32'(bus_if.vec), 32'h7);
    chk("pre next irq_n", 32'(bus_if.irq_n), 32'h0);
    bus_if.ack   = 1'b1;
    bus_if.req_n = 8'hFF;
    step(1);
    bus_if.ack = 1'b0;
    step(2);
    chk("pre end irq_n", 32'(bus_if.irq_n), 32'h1);
    chk("pre end pending", 32'(bus_if.pending), 32'h00);

`ifdef IRQ_EDGE_TRIG_EN
    // New edge on the granted bit in the ack cycle keeps it pending
    bus_if.req_n = 8'hFE;
    step(3);
    chk("sw grant vec", 32'(bus_if.vec), 32'h0);
    chk("sw grant irq_n", 32'(bus_if.irq_n), 32'h0);
    bus_if.req_n = 8'hFF;
    step(1);
    bus_if.req_n = 8'hFE;
    step(1);
    bus_if.ack = 1'b1;
    step(1);
    chk("sw ack irq_n", 32'(bus_if.irq_n), 32'h1);
    chk("sw ack pending", 32'(bus_if.pending), 32'h01);
    bus_if.ack = 1'b0;
    step(2);
    chk("sw regrant irq_n", 32'(bus_if.irq_n), 32'h0);
    chk("sw regrant vec", 32'(bus_if.vec), 32'h0);
    bus_if.ack = 1'b1;
    step(1);
    bus_if.ack   = 1'b0;
    bus_if.req_n = 8'hFF;
    step(2);
    chk("sw end pending", 32'(bus_if.pending), 32'h00);
`endif

    // Reset while ACTIVE
    bus_if.req_n = 8'hEF;
    step(LAT);
    chk("rst grant irq_n", 32'(bus_if.irq_n), 32'h0);
    chk("rst grant vec", 32'(bus_if.vec), 32'h4);
    reset = 1'b1;
    step(1);
    chk("rst irq_n", 32'(bus_if.irq_n), 32'h1);
    chk("rst pending", 32'(bus_if.pending), 32'h00);
    chk("rst vec", 32'(bus_if.vec), 32'h0);
    chk("rst timeout_p", 32'(bus_if.timeout_p), 32'h0);
    reset        = 1'b0;
    bus_if.req_n = 8'hFF;
    step(3);
    chk("rst after irq_n", 32'(bus_if.irq_n), 32'h1);
    chk("rst after pending", 32'(bus_if.pending), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
